// File: rtl/lane_neuron_pkg.sv
// Shared types, constants and clamp helper for the lane_neuron datapath.
// Optional build macro LANE_NEURON_SAT_FLAG_EN is consumed by the top, not here.
package lane_neuron_pkg;

    typedef enum logic [1:0] {
        ACT_RELU   = 2'd0,
        ACT_LINEAR = 2'd1,
        ACT_LEAKY  = 2'd2
    } act_mode_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ACCUM = 3'd1,
        DRAIN = 3'd2,
        BIAS  = 3'd3,
        ACT   = 3'd4,
        OUT   = 3'd5
    } state_t;

    localparam int LEAKY_SHIFT  = 3;
    localparam int DRAIN_CYCLES = 3;
    // Widest value sat_narrow can clamp; every caller sign-extends into this.
    localparam int NARROW_W     = 64;

    function automatic logic signed [NARROW_W-1:0] sat_narrow(
        input logic signed [NARROW_W-1:0] v,
        input int                         n
    );
        logic signed [NARROW_W-1:0] hi;
        logic signed [NARROW_W-1:0] lo;
        hi = (64'sd1 <<< (n - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    // Encoding 3 is a second linear code.
    function automatic act_mode_t decode_act(input logic [1:0] sel);
        case (sel)
            2'd0:    return ACT_RELU;
            2'd2:    return ACT_LEAKY;
            default: return ACT_LINEAR;
        endcase
    endfunction

endpackage

// File: rtl/lane_neuron_if.sv
// Beat input stream and result output stream of one neuron datapath.
interface lane_neuron_if #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_LANES  = 4
);
    logic                            in_valid;
    logic                            in_ready;
    logic [NUM_LANES*DATA_WIDTH-1:0] in_data;
    logic [NUM_LANES*DATA_WIDTH-1:0] in_weight;
    logic                            out_valid;
    logic                            out_ready;
    logic [DATA_WIDTH-1:0]           out_data;

    modport master (
        output in_valid, in_data, in_weight, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_weight, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/lane_neuron_sat_add.sv
// Saturating signed adder, result clamped to the WIDTH-bit signed range.
// Latency: combinational. Backpressure: none (pure datapath).
// ovf is high whenever the clamp engaged.
module lane_neuron_sat_add #(
    parameter int WIDTH = 32
) (
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic signed [WIDTH-1:0] sum,
    output logic                    ovf
);
    logic signed [WIDTH:0] full;

    always_comb begin
        full = (WIDTH+1)'(a) + (WIDTH+1)'(b);
        ovf  = full[WIDTH] != full[WIDTH-1];
        if (!ovf)
            sum = full[WIDTH-1:0];
        else if (full[WIDTH])
            sum = {1'b1, {(WIDTH-1){1'b0}}};
        else
            sum = {1'b0, {(WIDTH-1){1'b1}}};
    end
endmodule

// File: rtl/lane_neuron.sv
// Streaming neuron: NUM_LANES MACs per beat, saturating accumulate, bias, activation.
// Latency: out_valid 6 clocks after the last beat is accepted. Backpressure: in_ready only in ACCUM,
// result held until out_ready. Build macro LANE_NEURON_SAT_FLAG_EN adds the out_sat port.
module lane_neuron
    import lane_neuron_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_WIDTH = 12,
    parameter int NUM_INPUTS = 784,
    parameter int NUM_LANES  = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic signed [DATA_WIDTH-1:0] cfg_bias,
    input  logic [1:0]                   cfg_act,
    output logic                         busy,
`ifdef LANE_NEURON_SAT_FLAG_EN
    output logic                         out_sat,
`endif
    lane_neuron_if.slave                 bus
);
    localparam int BEATS      = (NUM_INPUTS + NUM_LANES - 1) / NUM_LANES;
    localparam int LAST_LANES = NUM_INPUTS - (BEATS - 1) * NUM_LANES;
    localparam int PROD_W     = 2 * DATA_WIDTH;
    localparam int SUM_W      = PROD_W + $clog2(NUM_LANES);
    localparam int CNT_W      = $clog2(BEATS + 1);

    state_t                    state, state_nxt;
    act_mode_t                 act_q;
    logic signed [DATA_WIDTH-1:0] bias_q;
    logic [CNT_W-1:0]          beat_cnt;
    logic [1:0]                drain_cnt;
    logic                      in_fire, out_fire, start_ok, last_beat;

    logic signed [PROD_W-1:0]  prod_c [NUM_LANES];
    logic signed [PROD_W-1:0]  prod_q [NUM_LANES];
    logic signed [SUM_W-1:0]   lane_sum, sum_q, acc_wide;
    logic signed [PROD_W-1:0]  acc_q, acc_nxt, bias_ext, biased_c, biased_q, shifted;
    logic signed [DATA_WIDTH-1:0] narrowed, act_res;
    logic                      s1_vld, s2_vld;
    logic                      add_ovf, acc_ovf, bias_ovf, narrow_ovf;

    assign in_fire   = bus.in_valid && bus.in_ready;
    assign out_fire  = bus.out_valid && bus.out_ready;
    assign start_ok  = start && (state == IDLE);
    assign last_beat = beat_cnt == CNT_W'(BEATS - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        busy         = state != IDLE;
        bus.in_ready = state == ACCUM;
        case (state)
            IDLE:    if (start) state_nxt = ACCUM;
            ACCUM:   if (in_fire && last_beat) state_nxt = DRAIN;
            DRAIN:   if (drain_cnt == 2'(DRAIN_CYCLES - 1)) state_nxt = BIAS;
            BIAS:    state_nxt = ACT;
            ACT:     state_nxt = OUT;
            OUT:     if (out_fire) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Lanes past NUM_INPUTS on the final beat are forced to zero before the tree.
    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) begin
            prod_c[i] = (last_beat && i >= LAST_LANES) ? '0 :
                PROD_W'($signed(bus.in_data[i*DATA_WIDTH +: DATA_WIDTH])) *
                PROD_W'($signed(bus.in_weight[i*DATA_WIDTH +: DATA_WIDTH]));
        end
        lane_sum = '0;
        for (int i = 0; i < NUM_LANES; i++)
            lane_sum = lane_sum + SUM_W'(prod_q[i]);
    end

    lane_neuron_sat_add #(.WIDTH(SUM_W)) u_acc_add (
        .a(SUM_W'(acc_q)), .b(sum_q), .sum(acc_wide), .ovf(add_ovf)
    );

    assign acc_nxt = PROD_W'(sat_narrow(NARROW_W'(acc_wide), PROD_W));
    assign acc_ovf = add_ovf || (sat_narrow(NARROW_W'(acc_wide), PROD_W) != NARROW_W'(acc_wide));

    assign bias_ext = PROD_W'(bias_q) <<< FRAC_WIDTH;

    lane_neuron_sat_add #(.WIDTH(PROD_W)) u_bias_add (
        .a(acc_q), .b(bias_ext), .sum(biased_c), .ovf(bias_ovf)
    );

    always_comb begin
        shifted    = biased_q >>> FRAC_WIDTH;
        narrowed   = DATA_WIDTH'(sat_narrow(NARROW_W'(shifted), DATA_WIDTH));
        narrow_ovf = sat_narrow(NARROW_W'(shifted), DATA_WIDTH) != NARROW_W'(shifted);
        act_res    = narrowed;
        if (narrowed[DATA_WIDTH-1]) begin
            if (act_q == ACT_RELU)       act_res = '0;
            else if (act_q == ACT_LEAKY) act_res = narrowed >>> LEAKY_SHIFT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_q         <= ACT_RELU;
            bias_q        <= '0;
            beat_cnt      <= '0;
            drain_cnt     <= '0;
            s1_vld        <= 1'b0;
            s2_vld        <= 1'b0;
            sum_q         <= '0;
            acc_q         <= '0;
            biased_q      <= '0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            for (int i = 0; i < NUM_LANES; i++) prod_q[i] <= '0;
        end else begin
            if (start_ok) begin
                act_q    <= decode_act(cfg_act);
                bias_q   <= cfg_bias;
                beat_cnt <= '0;
            end else if (in_fire) begin
                beat_cnt <= beat_cnt + CNT_W'(1);
            end
            drain_cnt <= (state == DRAIN) ? drain_cnt + 2'd1 : 2'd0;

            s1_vld <= in_fire;
            if (in_fire)
                for (int i = 0; i < NUM_LANES; i++) prod_q[i] <= prod_c[i];
            s2_vld <= s1_vld;
            if (s1_vld) sum_q <= lane_sum;

            if (start_ok)    acc_q <= '0;
            else if (s2_vld) acc_q <= acc_nxt;

            if (state == BIAS) biased_q     <= biased_c;
            if (state == ACT)  bus.out_data <= act_res;
            bus.out_valid <= (state == OUT) && !out_fire;
        end
    end

`ifdef LANE_NEURON_SAT_FLAG_EN
    logic sat_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sat_q <= 1'b0;
        else if (start_ok)
            sat_q <= 1'b0;
        else if ((s2_vld && acc_ovf) || (state == BIAS && bias_ovf) || (state == ACT && narrow_ovf))
            sat_q <= 1'b1;
    end
    assign out_sat = sat_q;
`else
    logic unused_ovf;
    assign unused_ovf = acc_ovf ^ bias_ovf ^ narrow_ovf;
`endif

endmodule

// File: tb/tb_lane_neuron.sv
// Directed bench: one 8-input and one 6-input neuron sharing a stimulus stream.
module tb_lane_neuron;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic        start8, start6, busy8, busy6, in_valid, out_ready;
    logic [15:0] cfg_bias;
    logic [1:0]  cfg_act;
    logic [63:0] in_data, in_weight;
    bit          cur_sel;

    lane_neuron_if #(.DATA_WIDTH(16), .NUM_LANES(4)) bus8 ();
    lane_neuron_if #(.DATA_WIDTH(16), .NUM_LANES(4)) bus6 ();

    assign bus8.in_valid  = in_valid;
    assign bus8.in_data   = in_data;
    assign bus8.in_weight = in_weight;
    assign bus8.out_ready = out_ready;
    assign bus6.in_valid  = in_valid;
    assign bus6.in_data   = in_data;
    assign bus6.in_weight = in_weight;
    assign bus6.out_ready = out_ready;

`ifdef LANE_NEURON_SAT_FLAG_EN
    logic sat8, sat6, sat_mux;
    assign sat_mux = cur_sel ? sat6 : sat8;
`endif

    lane_neuron #(.DATA_WIDTH(16), .FRAC_WIDTH(12), .NUM_INPUTS(8), .NUM_LANES(4)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .cfg_bias(cfg_bias), .cfg_act(cfg_act),
        .busy(busy8),
`ifdef LANE_NEURON_SAT_FLAG_EN
        .out_sat(sat8),
`endif
        .bus(bus8)
    );

    lane_neuron #(.DATA_WIDTH(16), .FRAC_WIDTH(12), .NUM_INPUTS(6), .NUM_LANES(4)) u_dut6 (
        .clk(clk), .rst_n(rst_n), .start(start6), .cfg_bias(cfg_bias), .cfg_act(cfg_act),
        .busy(busy6),
`ifdef LANE_NEURON_SAT_FLAG_EN
        .out_sat(sat6),
`endif
        .bus(bus6)
    );

    logic        rdy_mux, vld_mux, busy_mux;
    logic [15:0] dat_mux;
    assign rdy_mux  = cur_sel ? bus6.in_ready  : bus8.in_ready;
    assign vld_mux  = cur_sel ? bus6.out_valid : bus8.out_valid;
    assign busy_mux = cur_sel ? busy6 : busy8;
    assign dat_mux  = cur_sel ? bus6.out_data  : bus8.out_data;

    typedef struct {
        logic [15:0] d;
        logic [15:0] w;
        logic [15:0] bias;
        logic [1:0]  act;
        logic [15:0] exp_data;
        logic        exp_sat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Runs one neuron of two beats; hd/hw drive lanes 2,3 of the final beat.
    task automatic run(input bit sel, input logic [15:0] d, input logic [15:0] w,
                       input logic [15:0] hd, input logic [15:0] hw, input logic [15:0] bias,
                       input logic [1:0] act, input bit gap, input int stall,
                       output logic [15:0] res, output int lat);
        int beat, guard, acc_cyc;
        bit stable;
        beat = 0; guard = 0; acc_cyc = 0; stable = 1'b1;
        cur_sel = sel;
        @(negedge clk);
        cfg_bias = bias; cfg_act = act; start8 = !sel; start6 = sel;
        @(negedge clk);
        start8 = 1'b0; start6 = 1'b0;
        while (beat < 2 && guard < 40) begin
            in_valid  = gap ? guard[0] : 1'b1;
            in_data   = {4{d}};
            in_weight = {4{w}};
            if (beat == 1) begin
                in_data[63:32]   = {hd, hd};
                in_weight[63:32] = {hw, hw};
            end
            #1;
            if (in_valid && rdy_mux) begin
                beat++;
                if (beat == 2) acc_cyc = cyc + 1;
            end
            @(negedge clk);
            guard++;
        end
        in_valid = 1'b0;
        chk("in_ready_drop", {31'd0, rdy_mux}, 32'd0);
        while (!vld_mux && guard < 80) begin
            @(negedge clk);
            guard++;
        end
        chk("out_valid_seen", {31'd0, vld_mux}, 32'd1);
        lat = cyc - acc_cyc;
        res = dat_mux;
        for (int i = 0; i < stall; i++) begin
            if (i == 2) begin start8 = !sel; start6 = sel; end
            @(negedge clk);
            start8 = 1'b0; start6 = 1'b0;
            if (!vld_mux || dat_mux !== res) stable = 1'b0;
        end
        if (stall > 0) chk("hold_stable", {31'd0, stable}, 32'd1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("valid_drop", {31'd0, vld_mux}, 32'd0);
        chk("idle_after", {31'd0, busy_mux}, 32'd0);
    endtask

    initial begin
        vec_t        vt [11];
        logic [15:0] res;
        int          lat;

        vt[0]  = '{16'h1000, 16'h0800, 16'h0400, 2'd0, 16'h4400, 1'b0};
        vt[1]  = '{16'h1000, 16'hF800, 16'h0400, 2'd0, 16'h0000, 1'b0};
        vt[2]  = '{16'h1000, 16'hF800, 16'h0400, 2'd2, 16'hF880, 1'b0};
        vt[3]  = '{16'h1000, 16'hF800, 16'h0400, 2'd1, 16'hC400, 1'b0};
        vt[4]  = '{16'h1000, 16'hF800, 16'h0400, 2'd3, 16'hC400, 1'b0};
        vt[5]  = '{16'h7000, 16'h7000, 16'h0000, 2'd1, 16'h7FFF, 1'b1};
        vt[6]  = '{16'h9000, 16'h7000, 16'h0000, 2'd1, 16'h8000, 1'b1};
        vt[7]  = '{16'h0000, 16'h0000, 16'h0000, 2'd0, 16'h0000, 1'b0};
        vt[8]  = '{16'h0000, 16'h0000, 16'h7FFF, 2'd1, 16'h7FFF, 1'b0};
        vt[9]  = '{16'h1000, 16'h1000, 16'h0000, 2'd1, 16'h7FFF, 1'b1};
        vt[10] = '{16'h1000, 16'hF000, 16'h0000, 2'd2, 16'hF000, 1'b0};

        start8 = 1'b0; start6 = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; in_weight = '0; cfg_bias = '0; cfg_act = '0; cur_sel = 1'b0;

        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy8", {31'd0, busy8}, 32'd0);
        chk("rst_ready8", {31'd0, bus8.in_ready}, 32'd0);
        chk("rst_valid8", {31'd0, bus8.out_valid}, 32'd0);
        chk("rst_data8", {16'd0, bus8.out_data}, 32'd0);
        chk("rst_busy6", {31'd0, busy6}, 32'd0);
        chk("rst_valid6", {31'd0, bus6.out_valid}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            run(1'b0, vt[i].d, vt[i].w, vt[i].d, vt[i].w, vt[i].bias, vt[i].act, 1'b0, 0, res, lat);
            chk($sformatf("v%0d_data", i), {16'd0, res}, {16'd0, vt[i].exp_data});
            chk($sformatf("v%0d_latency", i), lat, 32'd6);
`ifdef LANE_NEURON_SAT_FLAG_EN
            chk($sformatf("v%0d_sat", i), {31'd0, sat_mux}, {31'd0, vt[i].exp_sat});
`endif
        end

        // Bubbled input, long output stall, start pulse during OUT
        run(1'b0, 16'h1000, 16'h0800, 16'h1000, 16'h0800, 16'h0400, 2'd0, 1'b1, 10, res, lat);
        chk("stall_data", {16'd0, res}, 32'h4400);
        chk("stall_latency", lat, 32'd6);

        // Masked lanes carry max-magnitude garbage, then zeros: both must agree
        run(1'b1, 16'h1000, 16'h0800, 16'h7FFF, 16'h7FFF, 16'h0400, 2'd0, 1'b0, 0, res, lat);
        chk("mask_garbage", {16'd0, res}, 32'h3400);
        chk("mask_latency", lat, 32'd6);
        run(1'b1, 16'h1000, 16'h0800, 16'h0000, 16'h0000, 16'h0400, 2'd0, 1'b0, 0, res, lat);
        chk("mask_zero", {16'd0, res}, 32'h3400);

        // Asynchronous reset in the middle of ACCUM
        cur_sel = 1'b0;
        @(negedge clk);
        cfg_bias = 16'h0100; cfg_act = 2'd1; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0; in_valid = 1'b1; in_data = {4{16'h7000}}; in_weight = {4{16'h7000}};
        @(negedge clk);
        in_valid = 1'b0;
        chk("mid_busy_before", {31'd0, busy8}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", {31'd0, busy8}, 32'd0);
        chk("arst_ready", {31'd0, bus8.in_ready}, 32'd0);
        chk("arst_valid", {31'd0, bus8.out_valid}, 32'd0);
        chk("arst_data", {16'd0, bus8.out_data}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run(1'b0, 16'h1000, 16'h0800, 16'h1000, 16'h0800, 16'h0400, 2'd0, 1'b0, 0, res, lat);
        chk("post_rst_data", {16'd0, res}, 32'h4400);
        chk("post_rst_latency", lat, 32'd6);
`ifdef LANE_NEURON_SAT_FLAG_EN
        chk("post_rst_sat", {31'd0, sat_mux}, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
